menu_nav_fsm: RTL and testbench
===============================

// Module: menu_nav_fsm
// PURPOSE
//  Parametrised front-end menu controller: TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME.
//  Drives the visibility flags, arrow cursor coordinates and car/control selections for the draw pipeline.
//  Generalises the fixed 4-car / 2-control menu to N_CARS and N_CTRL entries.
//  Adds edge-detected keys, bidirectional wrap-around navigation, ESC back-navigation and a race_start pulse.
// PARAMETERS
//  N_CARS     4    number of selectable cars, 2..15
//  N_CTRL     2    number of control schemes, 2..15
//  XY_W       11   coordinate width in bits (1024x768 screen)
//  CAR_X0     192  x of the first car tile
//  CAR_DX     192  x pitch between car tiles
//  CAR_AY     480  arrow y on the car screen
//  CTRL_X0    256  x of the first control tile
//  CTRL_DX    384  x pitch between control tiles
//  CTRL_AY    576  arrow y on the control screen
//  ARROW_OFS  16   arrow x offset inside a tile
// PORTS
//  pclk                    in   1       pixel clock; the only clock
//  rst                     in   1       synchronous, active-high reset
//  keycode                 in   8       raw PS/2 scan code; 0 = none
//  key                     in   6       decoded level keys {ESC,ENTER,RIGHT,LEFT,DOWN,UP}
//  title_screen_visible    out  1       title layer on
//  car_select_visible      out  1       car-select layer on
//  control_select_visible  out  1       control-select layer on
//  track_visible           out  1       track layer on
//  player_visible          out  1       player sprite on
//  car_visible             out  N_CARS  per-car tile on
//  arrow_visible           out  1       cursor sprite on
//  arrow_xpos              out  XY_W    cursor x
//  arrow_ypos              out  XY_W    cursor y
//  car                     out  4       chosen car, 1..N_CARS; 0 = none
//  control                 out  4       chosen control, 1..N_CTRL; 0 = none
//  lap_timer_start         out  1       high for the whole time in GAME
//  race_start              out  1       one-cycle pulse on entry to GAME
// BEHAVIOUR
//  Reset: state=TITLE; car_idx=0; ctrl_idx=0; key_q=0; kc_q=0; every output=0.
//  Events: ev = key & ~key_q. An event is valid only when ev is one-hot. Multi-bit ev is ignored entirely.
//  Title event: keycode!=0 && kc_q==0. key_q and kc_q are registered every cycle.
//  TITLE:   title event -> CAR_SELECT.
//  CAR_SELECT:
//   - RIGHT: car_idx+1, wraps N_CARS-1 -> 0.
//   - LEFT:  car_idx-1, wraps 0 -> N_CARS-1.
//   - ENTER: car <= car_idx+1, then -> CONTROL_SELECT.
//   - ESC:   -> TITLE.
//   - UP/DOWN: ignored.
//  CONTROL_SELECT:
//   - RIGHT/LEFT: ctrl_idx wraps the same way over N_CTRL.
//   - ENTER: control <= ctrl_idx+1, then -> GAME with race_start=1 for exactly one cycle.
//   - ESC:   -> CAR_SELECT; car is cleared to 0; car_idx is kept.
//  GAME:    ESC -> TITLE; car and control are cleared to 0. All other keys are ignored.
//  Indices persist across screens. They reset only on rst.
//  Outputs are registered and follow the state/index update with 1-cycle latency.
//   Key edge at cycle n -> state/index change at n+1 -> outputs at n+2.
//  Visibility per state:
//   - TITLE: title=1.
//   - CAR_SELECT: car_select=1, car_visible=all 1s, arrow=1.
//   - CONTROL_SELECT: control_select=1, arrow=1.
//   - GAME: track=1, player=1, lap_timer_start=1.
//   - Every flag not listed for a state is 0.
//  Arrow position:
//   - CAR_SELECT: x = CAR_X0 + car_idx*CAR_DX + ARROW_OFS, y = CAR_AY.
//   - CONTROL_SELECT: x = CTRL_X0 + ctrl_idx*CTRL_DX + ARROW_OFS, y = CTRL_AY.
//   - Any other state: x=0, y=0.
//   - Products are computed at XY_W bits. Truncation is a parameter error; no runtime check is made.
//  A held key produces exactly one event. The key must be released (its bit returns to 0) before it re-arms.
//  rst mid-menu: next cycle is TITLE with all outputs 0 and all selections lost.
// TESTING
//  1 rst, then keycode 8'h1C for 1 cycle -> CAR_SELECT; arrow=(208,480), car_visible=4'b1111.
//  2 Pulse RIGHT 4 times (N_CARS=4) -> arrow x goes 400,592,784,208 (wrap). Pulse LEFT once from idx0 -> x=784.
//  3 Hold RIGHT for 50 cycles -> car_idx advances exactly once.
//  4 In CAR_SELECT, key=ENTER|RIGHT on the same cycle -> no state or index change.
//  5 At idx2, ENTER; RIGHT; ENTER -> car=3, control=2, race_start pulses 1 cycle, lap_timer_start=1 held.
//  6 In GAME press ESC -> TITLE, car=0, control=0. Assert rst in CONTROL_SELECT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/menu_nav_fsm.sv
// Front-end menu controller: TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME.
// Edge-detects decoded keys, wraps the selection cursors, and drives registered
// visibility flags, arrow coordinates and car/control selections for drawing.
module menu_nav_fsm #(
  parameter int unsigned N_CARS    = 4,
  parameter int unsigned N_CTRL    = 2,
  parameter int unsigned XY_W      = 11,
  parameter int unsigned CAR_X0    = 192,
  parameter int unsigned CAR_DX    = 192,
  parameter int unsigned CAR_AY    = 480,
  parameter int unsigned CTRL_X0   = 256,
  parameter int unsigned CTRL_DX   = 384,
  parameter int unsigned CTRL_AY   = 576,
  parameter int unsigned ARROW_OFS = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [7:0]        keycode,
  input  logic [5:0]        key,
  output logic              title_screen_visible,
  output logic              car_select_visible,
  output logic              control_select_visible,
  output logic              track_visible,
  output logic              player_visible,
  output logic [N_CARS-1:0] car_visible,
  output logic              arrow_visible,
  output logic [XY_W-1:0]   arrow_xpos,
  output logic [XY_W-1:0]   arrow_ypos,
  output logic [3:0]        car,
  output logic [3:0]        control,
  output logic              lap_timer_start,
  output logic              race_start
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned K_UP    = 0;
  localparam int unsigned K_DOWN  = 1;
  localparam int unsigned K_LEFT  = 2;
  localparam int unsigned K_RIGHT = 3;
  localparam int unsigned K_ENTER = 4;
  localparam int unsigned K_ESC   = 5;

  typedef enum logic [1:0] {
    S_TITLE = 2'd0,
    S_CAR   = 2'd1,
    S_CTRL  = 2'd2,
    S_GAME  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] car_idx, car_idx_nxt;
  logic [IDX_W-1:0] ctrl_idx, ctrl_idx_nxt;
  logic [3:0]       sel_car, sel_car_nxt;
  logic [3:0]       sel_ctrl, sel_ctrl_nxt;
  logic             go_q, go_nxt;
  logic [5:0]       key_q;
  logic [7:0]       kc_q;

  logic [5:0]       ev_c;
  logic             ev_ok_c;
  logic             title_ev_c;
  logic [XY_W-1:0]  car_ax_c;
  logic [XY_W-1:0]  ctrl_ax_c;

  // Arrow x positions for the current cursor indices, computed at XY_W bits
  assign car_ax_c  = XY_W'(CAR_X0) + XY_W'(car_idx) * XY_W'(CAR_DX) + XY_W'(ARROW_OFS);
  assign ctrl_ax_c = XY_W'(CTRL_X0) + XY_W'(ctrl_idx) * XY_W'(CTRL_DX) + XY_W'(ARROW_OFS);

  // Rising-edge key events; only a single new key in a cycle counts
  assign ev_c       = key & ~key_q;
  assign ev_ok_c    = $onehot(ev_c);
  assign title_ev_c = (keycode != 8'd0) && (kc_q == 8'd0);

  // State, index, selection and key history registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= S_TITLE;
      car_idx  <= '0;
      ctrl_idx <= '0;
      sel_car  <= '0;
      sel_ctrl <= '0;
      go_q     <= 1'b0;
      key_q    <= '0;
      kc_q     <= '0;
    end else begin
      state    <= state_nxt;
      car_idx  <= car_idx_nxt;
      ctrl_idx <= ctrl_idx_nxt;
      sel_car  <= sel_car_nxt;
      sel_ctrl <= sel_ctrl_nxt;
      go_q     <= go_nxt;
      key_q    <= key;
      kc_q     <= keycode;
    end
  end

  // Next-state, cursor wrap and selection logic
  always_comb begin
    state_nxt    = state;
    car_idx_nxt  = car_idx;
    ctrl_idx_nxt = ctrl_idx;
    sel_car_nxt  = sel_car;
    sel_ctrl_nxt = sel_ctrl;
    go_nxt       = 1'b0;
    case (state)
      S_TITLE: begin
        if (title_ev_c) state_nxt = S_CAR;
      end
      S_CAR: begin
        if (ev_ok_c) begin
          if (ev_c[K_RIGHT]) begin
            car_idx_nxt = (car_idx == IDX_W'(N_CARS - 1)) ? '0 : car_idx + IDX_W'(1);
          end else if (ev_c[K_LEFT]) begin
            car_idx_nxt = (car_idx == '0) ? IDX_W'(N_CARS - 1) : car_idx - IDX_W'(1);
          end else if (ev_c[K_ENTER]) begin
            sel_car_nxt = car_idx + 4'd1;
            state_nxt   = S_CTRL;
          end else if (ev_c[K_ESC]) begin
            state_nxt = S_TITLE;
          end
        end
      end
      S_CTRL: begin
        if (ev_ok_c) begin
          if (ev_c[K_RIGHT]) begin
            ctrl_idx_nxt = (ctrl_idx == IDX_W'(N_CTRL - 1)) ? '0 : ctrl_idx + IDX_W'(1);
          end else if (ev_c[K_LEFT]) begin
            ctrl_idx_nxt = (ctrl_idx == '0) ? IDX_W'(N_CTRL - 1) : ctrl_idx - IDX_W'(1);
          end else if (ev_c[K_ENTER]) begin
            sel_ctrl_nxt = ctrl_idx + 4'd1;
            go_nxt       = 1'b1;
            state_nxt    = S_GAME;
          end else if (ev_c[K_ESC]) begin
            sel_car_nxt = '0;
            state_nxt   = S_CAR;
          end
        end
      end
      S_GAME: begin
        if (ev_ok_c && ev_c[K_ESC]) begin
          sel_car_nxt  = '0;
          sel_ctrl_nxt = '0;
          state_nxt    = S_TITLE;
        end
      end
      default: state_nxt = S_TITLE;
    endcase
  end

  // Registered draw-pipeline outputs, one cycle behind the state registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      title_screen_visible   <= 1'b0;
      car_select_visible     <= 1'b0;
      control_select_visible <= 1'b0;
      track_visible          <= 1'b0;
      player_visible         <= 1'b0;
      car_visible            <= '0;
      arrow_visible          <= 1'b0;
      arrow_xpos             <= '0;
      arrow_ypos             <= '0;
      car                    <= '0;
      control                <= '0;
      lap_timer_start        <= 1'b0;
      race_start             <= 1'b0;
    end else begin
      title_screen_visible   <= (state == S_TITLE);
      car_select_visible     <= (state == S_CAR);
      control_select_visible <= (state == S_CTRL);
      track_visible          <= (state == S_GAME);
      player_visible         <= (state == S_GAME);
      car_visible            <= (state == S_CAR) ? {N_CARS{1'b1}} : '0;
      arrow_visible          <= (state == S_CAR) || (state == S_CTRL);
      lap_timer_start        <= (state == S_GAME);
      race_start             <= go_q;
      car                    <= sel_car;
      control                <= sel_ctrl;
      case (state)
        S_CAR: begin
          arrow_xpos <= car_ax_c;
          arrow_ypos <= XY_W'(CAR_AY);
        end
        S_CTRL: begin
          arrow_xpos <= ctrl_ax_c;
          arrow_ypos <= XY_W'(CTRL_AY);
        end
        default: begin
          arrow_xpos <= '0;
          arrow_ypos <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menu_nav_fsm.sv
// Directed, table-driven bench for menu_nav_fsm with default parameters.
module tb_menu_nav_fsm;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  keycode;
  logic [5:0]  key;
  logic        title_screen_visible, car_select_visible, control_select_visible;
  logic        track_visible, player_visible, arrow_visible;
  logic [3:0]  car_visible;
  logic [10:0] arrow_xpos, arrow_ypos;
  logic [3:0]  car, control;
  logic        lap_timer_start, race_start;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] UP = 6'b000001, DN = 6'b000010, LT = 6'b000100,
                         RT = 6'b001000, EN = 6'b010000, ES = 6'b100000;

  typedef struct {
    logic [7:0] kc;
    logic [5:0] k;
    int         hold;
    int         st;     // 0 title, 1 car select, 2 control select, 3 game
    int         ax;
    int         ay;
    logic [3:0] car;
    logic [3:0] ctrl;
    int         races;
  } vec_t;

  vec_t tbl[24];

  menu_nav_fsm dut (
    .pclk(pclk), .rst(rst), .keycode(keycode), .key(key),
    .title_screen_visible(title_screen_visible),
    .car_select_visible(car_select_visible),
    .control_select_visible(control_select_visible),
    .track_visible(track_visible), .player_visible(player_visible),
    .car_visible(car_visible), .arrow_visible(arrow_visible),
    .arrow_xpos(arrow_xpos), .arrow_ypos(arrow_ypos),
    .car(car), .control(control),
    .lap_timer_start(lap_timer_start), .race_start(race_start)
  );

  always #5 pclk = ~pclk;

  logic [40:0] obs;
  assign obs = {title_screen_visible, car_select_visible, control_select_visible,
                track_visible, player_visible, arrow_visible, lap_timer_start,
                car_visible, arrow_xpos, arrow_ypos, car, control};

  function automatic vec_t mk(logic [7:0] kc, logic [5:0] k, int hold, int st,
                              int ax, int ay, logic [3:0] c, logic [3:0] t, int races);
    vec_t v;
    v.kc = kc; v.k = k; v.hold = hold; v.st = st; v.ax = ax; v.ay = ay;
    v.car = c; v.ctrl = t; v.races = races;
    return v;
  endfunction

  function automatic logic [40:0] exp_obs(int st, int ax, int ay, logic [3:0] c, logic [3:0] t);
    logic g;
    g = (st == 3);
    return {st == 0, st == 1, st == 2, g, g, (st == 1) || (st == 2), g,
            (st == 1) ? 4'hF : 4'h0, 11'(ax), 11'(ay), c, t};
  endfunction

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one key/keycode for 'hold' cycles, release, let outputs settle; count race pulses
  task automatic apply(input logic [7:0] kc, input logic [5:0] k, input int hold, output int races);
    races = 0;
    @(posedge pclk); #1;
    keycode = kc; key = k;
    repeat (hold) begin @(posedge pclk); #1; races += int'(race_start); end
    keycode = 8'h00; key = 6'b0;
    repeat (4) begin @(posedge pclk); #1; races += int'(race_start); end
  endtask

  initial begin
    int r;
    //           kc     key      hold st  ax   ay   car   ctrl  races
    tbl[0]  = mk(8'h1C, 6'b0,    1,   1, 208, 480, 4'd0, 4'd0, 0);
    tbl[1]  = mk(8'h00, RT,      1,   1, 400, 480, 4'd0, 4'd0, 0);
    tbl[2]  = mk(8'h00, RT,      1,   1, 592, 480, 4'd0, 4'd0, 0);
    tbl[3]  = mk(8'h00, RT,      1,   1, 784, 480, 4'd0, 4'd0, 0);
    tbl[4]  = mk(8'h00, RT,      1,   1, 208, 480, 4'd0, 4'd0, 0);
    tbl[5]  = mk(8'h00, LT,      1,   1, 784, 480, 4'd0, 4'd0, 0);
    tbl[6]  = mk(8'h00, RT,      50,  1, 208, 480, 4'd0, 4'd0, 0);
    tbl[7]  = mk(8'h00, RT,      50,  1, 400, 480, 4'd0, 4'd0, 0);
    tbl[8]  = mk(8'h00, UP,      1,   1, 400, 480, 4'd0, 4'd0, 0);
    tbl[9]  = mk(8'h00, EN | RT, 1,   1, 400, 480, 4'd0, 4'd0, 0);
    tbl[10] = mk(8'h00, RT,      1,   1, 592, 480, 4'd0, 4'd0, 0);
    tbl[11] = mk(8'h00, EN,      1,   2, 272, 576, 4'd3, 4'd0, 0);
    tbl[12] = mk(8'h00, RT,      1,   2, 656, 576, 4'd3, 4'd0, 0);
    tbl[13] = mk(8'h00, ES,      1,   1, 592, 480, 4'd0, 4'd0, 0);
    tbl[14] = mk(8'h00, EN,      1,   2, 656, 576, 4'd3, 4'd0, 0);
    tbl[15] = mk(8'h00, LT,      1,   2, 272, 576, 4'd3, 4'd0, 0);
    tbl[16] = mk(8'h00, LT,      1,   2, 656, 576, 4'd3, 4'd0, 0);
    tbl[17] = mk(8'h00, EN,      1,   3, 0,   0,   4'd3, 4'd2, 1);
    tbl[18] = mk(8'h00, RT,      1,   3, 0,   0,   4'd3, 4'd2, 0);
    tbl[19] = mk(8'h00, ES,      1,   0, 0,   0,   4'd0, 4'd0, 0);
    tbl[20] = mk(8'h00, ES,      1,   0, 0,   0,   4'd0, 4'd0, 0);
    tbl[21] = mk(8'h1C, 6'b0,    1,   1, 592, 480, 4'd0, 4'd0, 0);
    tbl[22] = mk(8'h1C, DN,      3,   1, 592, 480, 4'd0, 4'd0, 0);
    tbl[23] = mk(8'h00, EN,      1,   2, 656, 576, 4'd3, 4'd0, 0);

    rst = 1'b1; keycode = 8'h00; key = 6'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_outputs", obs, 41'd0);
    check_int("reset_race", int'(race_start), 0);
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("title_after_reset", obs, exp_obs(0, 0, 0, 4'd0, 4'd0));

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].kc, tbl[i].k, tbl[i].hold, r);
      check($sformatf("vec%0d_outputs", i), obs,
            exp_obs(tbl[i].st, tbl[i].ax, tbl[i].ay, tbl[i].car, tbl[i].ctrl));
      check_int($sformatf("vec%0d_race_pulses", i), r, tbl[i].races);
    end

    // Synchronous reset mid-menu clears everything on the next edge
    @(posedge pclk); #1;
    rst = 1'b1;
    @(posedge pclk); #1;
    check("midmenu_reset_outputs", obs, 41'd0);
    check_int("midmenu_reset_race", int'(race_start), 0);
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("title_after_midmenu_reset", obs, exp_obs(0, 0, 0, 4'd0, 4'd0));
    apply(8'h1C, 6'b0, 1, r);
    check("selection_lost_after_reset", obs, exp_obs(1, 208, 480, 4'd0, 4'd0));
    apply(8'h00, EN, 1, r);
    apply(8'h00, EN, 1, r);
    check("fresh_game_after_reset", obs, exp_obs(3, 0, 0, 4'd1, 4'd1));
    check_int("fresh_game_race_pulses", r, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
